// File: rtl/hilo_muldiv.sv
// HI/LO multiply-divide unit: MFHI/MTHI/MFLO/MTLO, pipelined-latency multiply and MADD/MSUB,
// and a 33-cycle radix-2 restoring divider. The EX stage is stalled while an operation is in flight.
module hilo_muldiv #(
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  typedef enum logic [3:0] {
    OP_NONE, OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO, OP_MULT, OP_MULTU,
    OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
  } op_t;

  state_t      state, state_n;
  op_t         op, op_q;
  logic [5:0]  cnt;
  logic [31:0] a_q, b_q, rem_q, quo_q, dvs_q;
  logic        rst_q;
  logic        is_hilo, is_mul, is_div, accept;

  always_comb begin
    op = OP_NONE;
    if (opcode == 6'b000000) begin
      case (funct)
        6'b010000: op = OP_MFHI;
        6'b010001: op = OP_MTHI;
        6'b010010: op = OP_MFLO;
        6'b010011: op = OP_MTLO;
        6'b011000: op = OP_MULT;
        6'b011001: op = OP_MULTU;
        6'b011010: op = OP_DIV;
        6'b011011: op = OP_DIVU;
        default:   op = OP_NONE;
      endcase
    end else if (opcode == 6'b011100) begin
      case (funct)
        6'b000000: op = OP_MADD;
        6'b000001: op = OP_MADDU;
        6'b000100: op = OP_MSUB;
        6'b000101: op = OP_MSUBU;
        default:   op = OP_NONE;
      endcase
    end
  end

  assign is_hilo = (op != OP_NONE);
  assign is_mul  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
                   (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  assign is_div  = (op == OP_DIV) || (op == OP_DIVU);

  // Gating with rst/rst_q keeps the handshake quiet during reset and the cycle after it.
  assign busy         = (state != IDLE) && !rst;
  assign stall        = valid && is_hilo && busy && !flush;
  assign accept       = valid && is_hilo && !busy && !flush && !rst && !rst_q;
  assign result_valid = accept && ((op == OP_MFHI) || (op == OP_MFLO));
  assign result       = !result_valid ? 32'd0 : (op == OP_MFHI) ? hi : lo;

  // Multiply datapath, evaluated from latched operands at commit.
  logic        mul_signed;
  logic [63:0] a_ext, b_ext, prod, mul_res;
  assign mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
  assign a_ext = mul_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign b_ext = mul_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign prod  = a_ext * b_ext;

  always_comb begin
    case (op_q)
      OP_MADD, OP_MADDU: mul_res = {hi, lo} + prod;
      OP_MSUB, OP_MSUBU: mul_res = {hi, lo} - prod;
      default:           mul_res = prod;
    endcase
  end

  // Divider: one restoring step per cycle on magnitudes, signs applied in the final cycle.
  logic        dsigned, a_neg, b_neg;
  logic [31:0] abs_a, abs_b;
  logic [32:0] sh, diff;
  logic [31:0] rem_nx, q_fix, r_fix;
  assign dsigned = (op == OP_DIV);
  assign abs_a   = (dsigned && op_a[31]) ? -op_a : op_a;
  assign abs_b   = (dsigned && op_b[31]) ? -op_b : op_b;
  assign sh      = {rem_q, quo_q[31]};
  assign diff    = sh - {1'b0, dvs_q};
  assign rem_nx  = diff[32] ? sh[31:0] : diff[31:0];
  assign a_neg   = (op_q == OP_DIV) && a_q[31];
  assign b_neg   = (op_q == OP_DIV) && b_q[31];
  assign q_fix   = (a_neg ^ b_neg) ? -quo_q : quo_q;
  assign r_fix   = a_neg ? -rem_q : rem_q;

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept && is_mul)      state_n = MUL;
          else if (accept && is_div) state_n = DIV;
        end
        MUL:     if (cnt == 6'd0) state_n = IDLE;
        DIV:     if (cnt == 6'd0) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rst_q <= 1'b1;
      hi    <= 32'd0;
      lo    <= 32'd0;
      cnt   <= 6'd0;
      op_q  <= OP_NONE;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      rem_q <= 32'd0;
      quo_q <= 32'd0;
      dvs_q <= 32'd0;
    end else begin
      rst_q <= 1'b0;
      state <= state_n;
      if (accept) begin
        if (op == OP_MTHI) hi <= op_a;
        if (op == OP_MTLO) lo <= op_a;
        if (is_mul || is_div) begin
          op_q <= op;
          a_q  <= op_a;
          b_q  <= op_b;
        end
        if (is_mul) cnt <= 6'(MUL_CYCLES - 1);
        if (is_div) begin
          cnt   <= 6'd32;
          rem_q <= 32'd0;
          quo_q <= abs_a;
          dvs_q <= abs_b;
        end
      end else if (!flush) begin
        case (state)
          MUL: begin
            if (cnt == 6'd0) {hi, lo} <= mul_res;
            else             cnt <= cnt - 6'd1;
          end
          DIV: begin
            if (cnt != 6'd0) begin
              rem_q <= rem_nx;
              quo_q <= {quo_q[30:0], ~diff[32]};
              cnt   <= cnt - 6'd1;
            end else if (b_q == 32'd0) begin
              lo <= 32'hFFFF_FFFF;
              hi <= a_q;
            end else begin
              lo <= q_fix;
              hi <= r_fix;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: hand-computed HI/LO results, latencies, stall, flush and reset.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rst, valid, flush;
  logic [5:0]  opcode, funct;
  logic [31:0] op_a, op_b;
  logic        stall, result_valid, busy;
  logic [31:0] result, hi, lo;

  int checks = 0;
  int errors = 0;
  int n;

  localparam logic [5:0] SPC = 6'b000000, SP2 = 6'b011100;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001, F_MFLO = 6'b010010,
                         F_MTLO = 6'b010011, F_MULT = 6'b011000, F_MULTU = 6'b011001,
                         F_DIV = 6'b011010, F_DIVU = 6'b011011, F_MADD = 6'b000000,
                         F_MSUBU = 6'b000101, F_ADD = 6'b100000;

  hilo_muldiv #(.MUL_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .valid(valid), .opcode(opcode), .funct(funct),
    .op_a(op_a), .op_b(op_b), .flush(flush), .stall(stall), .result(result),
    .result_valid(result_valid), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] oc, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    valid = 1'b1; opcode = oc; funct = fn; op_a = a; op_b = b;
  endtask

  task automatic nop;
    valid = 1'b0; opcode = 6'd0; funct = 6'd0; op_a = 32'd0; op_b = 32'd0;
  endtask

  // Call in the cycle after accept; n = number of busy cycles observed.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      tick;
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; nop;
    tick;
    issue(SPC, F_MFLO, 32'd0, 32'd0); #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rv", {31'd0, result_valid}, 32'd0);
    tick;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    rst = 1'b0; #1;
    chk("post_rst_rv", {31'd0, result_valid}, 32'd0);
    tick; nop;

    // MTLO then MFLO
    issue(SPC, F_MTLO, 32'h1234_5678, 32'd0); tick;
    issue(SPC, F_MFLO, 32'd0, 32'd0); #1;
    chk("mflo_result", result, 32'h1234_5678);
    chk("mflo_rv", {31'd0, result_valid}, 32'd1);
    chk("mflo_stall", {31'd0, stall}, 32'd0);
    tick; nop; #1;
    chk("idle_rv", {31'd0, result_valid}, 32'd0);

    // MULT / MULTU
    issue(SPC, F_MULT, 32'hFFFF_FFFE, 32'd3); tick; nop;
    wait_idle(n);
    chk("mult_lat", n, 32'd3);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    issue(SPC, F_MULTU, 32'hFFFF_FFFE, 32'd3); tick; nop;
    wait_idle(n);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    // DIV -7/2, DIVU 7/0, DIV overflow case
    issue(SPC, F_DIV, 32'hFFFF_FFF9, 32'd2); tick; nop;
    wait_idle(n);
    chk("div_lat", n, 32'd33);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    issue(SPC, F_DIVU, 32'd7, 32'd0); tick; nop;
    wait_idle(n);
    chk("div0_lat", n, 32'd33);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'd7);
    issue(SPC, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF); tick; nop;
    wait_idle(n);
    chk("divov_lo", lo, 32'h8000_0000);
    chk("divov_hi", hi, 32'd0);

    // MFHI presented in the second cycle after DIVU 100/7 accept: stalls 32 cycles
    issue(SPC, F_DIVU, 32'd100, 32'd7); tick; nop; tick;
    issue(SPC, F_MFHI, 32'd0, 32'd0); #1;
    n = 0;
    while (stall && n < 100) begin
      n++;
      tick;
    end
    chk("mfhi_stall_cyc", n, 32'd32);
    chk("mfhi_result", result, 32'd2);
    chk("mfhi_rv", {31'd0, result_valid}, 32'd1);
    chk("divu_lo", lo, 32'd14);
    tick; nop;

    // MADD / MSUBU
    issue(SPC, F_MTHI, 32'd0, 32'd0); tick;
    issue(SPC, F_MTLO, 32'hFFFF_FFFF, 32'd0); tick;
    issue(SP2, F_MADD, 32'd1, 32'd1); tick; nop;
    wait_idle(n);
    chk("madd_hi", hi, 32'd1);
    chk("madd_lo", lo, 32'd0);
    issue(SPC, F_MTHI, 32'd0, 32'd0); tick;
    issue(SPC, F_MTLO, 32'd0, 32'd0); tick;
    issue(SP2, F_MSUBU, 32'd1, 32'd1); tick; nop;
    wait_idle(n);
    chk("msubu_hi", hi, 32'hFFFF_FFFF);
    chk("msubu_lo", lo, 32'hFFFF_FFFF);

    // Non-HILO while busy, then flush on cycle 10 of a DIV with a same-cycle MTHI
    issue(SPC, F_DIVU, 32'd100, 32'd7); tick;
    issue(SPC, F_ADD, 32'd1, 32'd2); #1;
    chk("nonhilo_stall", {31'd0, stall}, 32'd0);
    chk("nonhilo_busy", {31'd0, busy}, 32'd1);
    nop;
    for (int i = 0; i < 9; i++) tick;
    issue(SPC, F_MTHI, 32'h0000_DEAD, 32'd0); flush = 1'b1; #1;
    chk("flush_stall", {31'd0, stall}, 32'd0);
    tick; nop; flush = 1'b0; #1;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 40; i++) tick;
    chk("flush_hi", hi, 32'hFFFF_FFFF);
    chk("flush_lo", lo, 32'hFFFF_FFFF);

    // Signed MADD with a negative product: 10 + (-1*3) = 7
    issue(SPC, F_MTHI, 32'd0, 32'd0); tick;
    issue(SPC, F_MTLO, 32'd10, 32'd0); tick;
    issue(SP2, F_MADD, 32'hFFFF_FFFF, 32'd3); tick; nop;
    wait_idle(n);
    chk("madd_neg_hi", hi, 32'd0);
    chk("madd_neg_lo", lo, 32'd7);

    // Reset in the middle of a MULT
    issue(SPC, F_MTHI, 32'd5, 32'd0); tick;
    issue(SPC, F_MULT, 32'd2, 32'd3); tick; nop; tick;
    rst = 1'b1; #1;
    chk("rstmul_busy_in", {31'd0, busy}, 32'd0);
    tick; rst = 1'b0; #1;
    chk("rstmul_busy", {31'd0, busy}, 32'd0);
    chk("rstmul_hi", hi, 32'd0);
    chk("rstmul_lo", lo, 32'd0);
    for (int i = 0; i < 5; i++) tick;
    chk("rstmul_lo_late", lo, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
